uc_multiciclo: RTL and testbench

- Multicycle control unit for the `fd` RV64I datapath.
- Consumes the opcode, funct fields and ALU flags from the datapath.
- Drives every datapath strobe and mux select through a Moore FSM, with a Mealy branch-decision term in one state.
- Sequences one instruction at a time: fetch, decode, execute, then optional memory and write-back.

---
 rtl/uc_multiciclo_if.sv | 42 ++++
 rtl/uc_multiciclo.sv | 238 +++++++++++++++++++++++
 tb/tb_uc_multiciclo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uc_multiciclo_if.sv
// uc_multiciclo_if -- control bus between the multicycle control unit and the
// fd RV64I datapath.
//   Datapath -> control : opcode, funct3, funct7_b30, alu_flags
//                         (alu_flags: [0] zero, [1] msb, [2] signed overflow,
//                          [3] unsigned borrow)
//   Control -> datapath : ir_we, pc_we, pc_src, pc_base, alu_src, alu_cmd,
//                         rf_we, rf_src, d_mem_we
//   Status              : illegal (sticky), retire (pulse), retired_cnt
// The control unit uses the master modport. The datapath side uses the slave modport.
interface uc_multiciclo_if #(
  parameter int RETIRE_BITS = 32
);
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic                   funct7_b30;
  logic [3:0]             alu_flags;

  logic                   ir_we;
  logic                   pc_we;
  logic                   pc_src;
  logic                   pc_base;
  logic                   alu_src;
  logic [3:0]             alu_cmd;
  logic                   rf_we;
  logic [1:0]             rf_src;
  logic                   d_mem_we;
  logic                   illegal;
  logic                   retire;
  logic [RETIRE_BITS-1:0] retired_cnt;

  modport master (
    input  opcode, funct3, funct7_b30, alu_flags,
    output ir_we, pc_we, pc_src, pc_base, alu_src, alu_cmd,
           rf_we, rf_src, d_mem_we, illegal, retire, retired_cnt
  );

  modport slave (
    output opcode, funct3, funct7_b30, alu_flags,
    input  ir_we, pc_we, pc_src, pc_base, alu_src, alu_cmd,
           rf_we, rf_src, d_mem_we, illegal, retire, retired_cnt
  );
endinterface

// File: rtl/uc_multiciclo.sv
// uc_multiciclo -- multicycle control unit for the fd RV64I datapath.
// The unit processes one instruction at a time in this order:
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Every strobe and select is a registered Moore output of the state being
// entered. There is one exception: in EXEC of a conditional branch, pc_src
// also depends on the live ALU flags.
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low (aborts any instruction in flight)
//   bus    : uc_multiciclo_if.master (decode fields in, control strobes out)
module uc_multiciclo #(
  parameter int RETIRE_BITS = 32
) (
  input logic            clk,
  input logic            rst_n,
  uc_multiciclo_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_AUIPC, C_LUI, C_BAD
  } cls_e;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic       pc_base;
    logic       alu_src;
    logic [3:0] alu_cmd;
    logic       rf_we;
    logic [1:0] rf_src;
    logic       d_mem_we;
    logic       retire;
  } ctrl_t;

  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_S  = 4'b0010;
  localparam logic [3:0] ALU_SB = 4'b0011;
  localparam logic [3:0] ALU_U  = 4'b0100;
  localparam logic [3:0] ALU_UJ = 4'b0101;

  localparam logic [1:0] RF_ALU  = 2'b00;
  localparam logic [1:0] RF_MEM  = 2'b01;
  localparam logic [1:0] RF_PC4  = 2'b10;
  localparam logic [1:0] RF_PCIM = 2'b11;

  function automatic cls_e classify(input logic [6:0] opc);
    case (opc)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0010111: return C_AUIPC;
      7'b0110111: return C_LUI;
      default:    return C_BAD;
    endcase
  endfunction

  // Branch funct3 values 010 and 011 are not defined and are flagged as illegal.
  function automatic logic branch_f3_bad(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // alu_flags: [0] Z, [1] N, [2] V, [3] C (unsigned borrow).
  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] fl);
    case (f3)
      3'b000:  return fl[0];
      3'b001:  return !fl[0];
      3'b100:  return fl[1] ^ fl[2];
      3'b101:  return !(fl[1] ^ fl[2]);
      3'b110:  return fl[3];
      3'b111:  return !fl[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic state_e next_of(input state_e s, input cls_e c);
    case (s)
      S_IDLE:   return S_FETCH;
      S_FETCH:  return S_DECODE;
      // An unsupported opcode skips EXEC. It only advances PC in the WB slot.
      S_DECODE: return (c == C_BAD) ? S_WB : S_EXEC;
      S_EXEC: begin
        case (c)
          C_BRANCH:       return S_FETCH;
          C_LOAD, C_STORE: return S_MEM;
          default:        return S_WB;
        endcase
      end
      S_MEM:    return (c == C_LOAD) ? S_WB : S_FETCH;
      default:  return S_FETCH;
    endcase
  endfunction

  // Moore outputs of state s for instruction class c. Fields not set here stay 0.
  function automatic ctrl_t ctrl_of(input state_e s, input cls_e c);
    ctrl_t k;
    k = '0;
    case (s)
      S_FETCH: k.ir_we = 1'b1;
      S_EXEC: begin
        case (c)
          C_R:             begin k.alu_cmd = ALU_R;  k.alu_src = 1'b0; end
          C_I, C_LOAD,
          C_JALR:          begin k.alu_cmd = ALU_I;  k.alu_src = 1'b1; end
          C_STORE:         begin k.alu_cmd = ALU_S;  k.alu_src = 1'b1; end
          C_AUIPC, C_LUI:  begin k.alu_cmd = ALU_U;  k.alu_src = 1'b1; end
          C_JAL:           k.alu_cmd = ALU_UJ;
          C_BRANCH: begin
            k.alu_cmd = ALU_SB;
            k.pc_we   = 1'b1;
            k.retire  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (c == C_STORE) begin
          k.alu_cmd  = ALU_S;
          k.alu_src  = 1'b1;
          k.d_mem_we = 1'b1;
          k.pc_we    = 1'b1;
          k.retire   = 1'b1;
        end else begin
          k.alu_cmd  = ALU_I;
          k.alu_src  = 1'b1;
        end
      end
      S_WB: begin
        k.pc_we  = 1'b1;
        k.retire = 1'b1;
        case (c)
          C_R, C_I, C_LUI: begin k.rf_we = 1'b1; k.rf_src = RF_ALU;  end
          C_LOAD:          begin k.rf_we = 1'b1; k.rf_src = RF_MEM;  end
          C_AUIPC:         begin k.rf_we = 1'b1; k.rf_src = RF_PCIM; end
          C_JAL: begin
            k.rf_we  = 1'b1;
            k.rf_src = RF_PC4;
            k.pc_src = 1'b1;
          end
          C_JALR: begin
            k.rf_we   = 1'b1;
            k.rf_src  = RF_PC4;
            k.pc_src  = 1'b1;
            k.pc_base = 1'b1;
            k.alu_cmd = ALU_I;
            k.alu_src = 1'b1;
          end
          default: ;  // unsupported opcode: PC+4 only
        endcase
      end
      default: ;
    endcase
    return k;
  endfunction

  state_e                 state, state_nxt;
  cls_e                   cls_live, cls_q, cls_sel;
  logic [6:0]             opcode_q;
  logic [2:0]             funct3_q;
  logic                   funct7_b30_q;
  ctrl_t                  ctrl_q;
  logic                   illegal_q;
  logic [RETIRE_BITS-1:0] cnt_q;
  logic                   br_pc_src;

  // The latched funct7_b30 is held with the other IR fields. No control
  // decision in this unit depends on it.
  logic unused_funct7;
  assign unused_funct7 = funct7_b30_q;

  // In DECODE the fields are still arriving, so this cycle classifies the live
  // opcode. After DECODE only the latched copy is used.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path
    // leaves a variable unassigned and no latch is inferred.
    cls_live  = classify(bus.opcode);
    cls_q     = classify(opcode_q);
    cls_sel   = cls_q;
    if (state == S_DECODE) cls_sel = cls_live;
    state_nxt = next_of(state, cls_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ctrl_q       <= '0;
      illegal_q    <= 1'b0;
      cnt_q        <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      funct7_b30_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples values from before the edge, whatever the statement order.
      state  <= state_nxt;
      ctrl_q <= ctrl_of(state_nxt, cls_sel);

      if (state == S_DECODE) begin
        opcode_q     <= bus.opcode;
        funct3_q     <= bus.funct3;
        funct7_b30_q <= bus.funct7_b30;
        if (cls_live == C_BAD ||
            (cls_live == C_BRANCH && branch_f3_bad(bus.funct3)))
          illegal_q <= 1'b1;
      end

      // Counts the retire pulse of the cycle that is ending. The counter wraps freely.
      if (ctrl_q.retire) cnt_q <= cnt_q + RETIRE_BITS'(1);
    end
  end

  // This is the Mealy term: the branch decision in EXEC uses the latched funct3 and
  // the flags the ALU produces during that same cycle.
  assign br_pc_src = (state == S_EXEC) && (cls_q == C_BRANCH) &&
                     branch_taken(funct3_q, bus.alu_flags);

  assign bus.ir_we       = ctrl_q.ir_we;
  assign bus.pc_we       = ctrl_q.pc_we;
  assign bus.pc_src      = ctrl_q.pc_src | br_pc_src;
  assign bus.pc_base     = ctrl_q.pc_base;
  assign bus.alu_src     = ctrl_q.alu_src;
  assign bus.alu_cmd     = ctrl_q.alu_cmd;
  assign bus.rf_we       = ctrl_q.rf_we;
  assign bus.rf_src      = ctrl_q.rf_src;
  assign bus.d_mem_we    = ctrl_q.d_mem_we;
  assign bus.retire      = ctrl_q.retire;
  assign bus.illegal     = illegal_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo -- directed, table-driven bench for uc_multiciclo.
// Two instances share the same stimulus. The second one uses RETIRE_BITS=4 to
// show that the counter wraps.
// Each cycle's outputs are packed as
//   {ir_we, pc_we, pc_src, pc_base, alu_src, alu_cmd[3:0],
//    rf_we, rf_src[1:0], d_mem_we, retire, illegal}.
// Inputs are driven and outputs sampled on the falling edge.
module tb_uc_multiciclo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uc_multiciclo_if #(.RETIRE_BITS(32)) bus  ();
  uc_multiciclo_if #(.RETIRE_BITS(4))  bus4 ();

  uc_multiciclo #(.RETIRE_BITS(32)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  uc_multiciclo #(.RETIRE_BITS(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  assign bus4.opcode     = bus.opcode;
  assign bus4.funct3     = bus.funct3;
  assign bus4.funct7_b30 = bus.funct7_b30;
  assign bus4.alu_flags  = bus.alu_flags;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [3:0] fl;
    int         lat;
    logic [14:0] c3, c4, c5;
    bit         sets_ill;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic        ill_model;
  logic [31:0] cnt_model;
  vec_t        tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] mk(input logic ir, input logic pcwe, input logic pcsrc,
                                     input logic pcbase, input logic alusrc,
                                     input logic [3:0] cmd, input logic rfwe,
                                     input logic [1:0] rfsrc, input logic dmem,
                                     input logic ret);
    return {ir, pcwe, pcsrc, pcbase, alusrc, cmd, rfwe, rfsrc, dmem, ret, 1'b0};
  endfunction

  function automatic logic [14:0] obs();
    return {bus.ir_we, bus.pc_we, bus.pc_src, bus.pc_base, bus.alu_src, bus.alu_cmd,
            bus.rf_we, bus.rf_src, bus.d_mem_we, bus.retire, bus.illegal};
  endfunction

  function automatic vec_t nv(input string name, input logic [6:0] opc, input logic [2:0] f3,
                              input logic [3:0] fl, input int lat, input logic [14:0] c3,
                              input logic [14:0] c4, input logic [14:0] c5, input bit ill);
    vec_t v;
    v.name = name; v.opc = opc; v.f3 = f3; v.fl = fl; v.lat = lat;
    v.c3 = c3; v.c4 = c4; v.c5 = c5; v.sets_ill = ill;
    return v;
  endfunction

  // Start at a falling edge while the DUT is in FETCH. End at the falling edge
  // of the next FETCH.
  task automatic run_vec(input vec_t v);
    logic [14:0] exp;
    bus.opcode     = v.opc;
    bus.funct3     = v.f3;
    bus.funct7_b30 = 1'b0;
    bus.alu_flags  = v.fl;
    for (int c = 1; c <= v.lat; c++) begin
      case (c)
        1:       exp = mk(1, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 0);
        2:       exp = '0;
        3:       exp = v.c3;
        4:       exp = v.c4;
        default: exp = v.c5;
      endcase
      exp[0] = ill_model | (v.sets_ill && c >= 3);
      check($sformatf("%s cyc%0d", v.name, c), 64'(obs()), 64'(exp));
      @(negedge clk);
    end
    ill_model = ill_model | v.sets_ill;
    cnt_model = cnt_model + 1;
    check($sformatf("%s retired_cnt", v.name), 64'(bus.retired_cnt), 64'(cnt_model));
    check($sformatf("%s retired_cnt4", v.name), 64'(bus4.retired_cnt), 64'(cnt_model[3:0]));
  endtask

  // Release reset just after a rising edge. This gives one full IDLE cycle and then FETCH.
  task automatic do_release();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle outputs", 64'(obs()), 64'd0);
    check("idle retired_cnt", 64'(bus.retired_cnt), 64'd0);
    @(negedge clk);
    check("first fetch", 64'(obs()), 64'(mk(1, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 0)));
    ill_model = 1'b0;
    cnt_model = '0;
  endtask

  initial begin
    tbl[0]  = nv("ADD",    7'b0110011, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 0, 4'b0000, 1, 2'b00, 0, 1), '0, 0);
    tbl[1]  = nv("ADDI",   7'b0010011, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 1, 4'b0001, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 0, 4'b0000, 1, 2'b00, 0, 1), '0, 0);
    tbl[2]  = nv("LOAD",   7'b0000011, 3'b011, 4'b0000, 5,
                 mk(0, 0, 0, 0, 1, 4'b0001, 0, 2'b00, 0, 0),
                 mk(0, 0, 0, 0, 1, 4'b0001, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 0, 4'b0000, 1, 2'b01, 0, 1), 0);
    tbl[3]  = nv("STORE",  7'b0100011, 3'b011, 4'b0000, 4,
                 mk(0, 0, 0, 0, 1, 4'b0010, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 1, 4'b0010, 0, 2'b00, 1, 1), '0, 0);
    tbl[4]  = nv("BEQ_T",  7'b1100011, 3'b000, 4'b0001, 3,
                 mk(0, 1, 1, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 0);
    tbl[5]  = nv("BEQ_NT", 7'b1100011, 3'b000, 4'b0000, 3,
                 mk(0, 1, 0, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 0);
    tbl[6]  = nv("BLTU_T", 7'b1100011, 3'b110, 4'b1000, 3,
                 mk(0, 1, 1, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 0);
    tbl[7]  = nv("BGE_T",  7'b1100011, 3'b101, 4'b0110, 3,
                 mk(0, 1, 1, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 0);
    tbl[8]  = nv("BNE_NT", 7'b1100011, 3'b001, 4'b0001, 3,
                 mk(0, 1, 0, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 0);
    tbl[9]  = nv("BLT_T",  7'b1100011, 3'b100, 4'b0100, 3,
                 mk(0, 1, 1, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 0);
    tbl[10] = nv("JALR",   7'b1100111, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 1, 4'b0001, 0, 2'b00, 0, 0),
                 mk(0, 1, 1, 1, 1, 4'b0001, 1, 2'b10, 0, 1), '0, 0);
    tbl[11] = nv("JAL",    7'b1101111, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 0, 4'b0101, 0, 2'b00, 0, 0),
                 mk(0, 1, 1, 0, 0, 4'b0000, 1, 2'b10, 0, 1), '0, 0);
    tbl[12] = nv("AUIPC",  7'b0010111, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 1, 4'b0100, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 0, 4'b0000, 1, 2'b11, 0, 1), '0, 0);
    tbl[13] = nv("LUI",    7'b0110111, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 1, 4'b0100, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 0, 4'b0000, 1, 2'b00, 0, 1), '0, 0);
    tbl[14] = nv("ILLOP",  7'b1111111, 3'b000, 4'b0000, 3,
                 mk(0, 1, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 1), '0, '0, 1);
    tbl[15] = nv("ADD2",   7'b0110011, 3'b000, 4'b0000, 4,
                 mk(0, 0, 0, 0, 0, 4'b0000, 0, 2'b00, 0, 0),
                 mk(0, 1, 0, 0, 0, 4'b0000, 1, 2'b00, 0, 1), '0, 0);
    tbl[16] = nv("BR_F3BAD", 7'b1100011, 3'b010, 4'b0001, 3,
                 mk(0, 1, 0, 0, 0, 4'b0011, 0, 2'b00, 0, 1), '0, '0, 1);

    rst_n          = 1'b0;
    bus.opcode     = '0;
    bus.funct3     = '0;
    bus.funct7_b30 = 1'b0;
    bus.alu_flags  = '0;
    ill_model      = 1'b0;
    cnt_model      = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", 64'(obs()), 64'd0);
    do_release();

    // Run every table vector once. The run ends at 17 retires.
    for (int i = 0; i < 17; i++) run_vec(tbl[i]);
    check("wrap cnt4 after 17", 64'(bus4.retired_cnt), 64'd1);
    check("fetch after table", 64'(bus.ir_we), 64'd1);

    // Assert reset during the MEM cycle of a STORE.
    bus.opcode    = 7'b0100011;
    bus.funct3    = 3'b011;
    bus.alu_flags = 4'b0000;
    repeat (3) @(negedge clk);
    check("store mem d_mem_we", 64'(bus.d_mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort d_mem_we", 64'(bus.d_mem_we), 64'd0);
    check("abort pc_we", 64'(bus.pc_we), 64'd0);
    check("abort retired_cnt", 64'(bus.retired_cnt), 64'd0);
    check("abort illegal", 64'(bus.illegal), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("in reset strobes %0d", k),
            64'({bus.pc_we, bus.rf_we, bus.d_mem_we}), 64'd0);
    end
    do_release();

    // Run LOAD and STORE back to back, then an undefined branch funct3 with illegal clear.
    run_vec(tbl[2]);
    run_vec(tbl[3]);
    check("ld/st retired_cnt", 64'(bus.retired_cnt), 64'd2);
    run_vec(tbl[16]);
    check("illegal after bad branch", 64'(bus.illegal), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
